// File: rtl/grf_scoreboard_pkg.sv
// Shared CPU register-file definitions: index constants, default widths and
// the helper that locates port i inside a flattened multi-port bus.
package grf_scoreboard_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  // Low bit of slice idx in a bus made of equal-width fields; use with +:.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/grf_wr_select.sv
// Priority resolution of the write ports for one register index.
// The highest-numbered enabled port that targets addr wins.
module grf_wr_select
  import grf_scoreboard_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_WR = 2
) (
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  // Walk ports low to high so a later (higher) match overrides earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p] && (wr_addr[slice_lo(p, ADDR_W) +: ADDR_W] == addr)) begin
        hit  = 1'b1;
        data = wr_data[slice_lo(p, DATA_W) +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/grf_scoreboard.sv
// Multi-port general register file with optional write-to-read bypass and a
// per-register busy scoreboard that raises stall on RAW hazards.
module grf_scoreboard
  import grf_scoreboard_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_used,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs     [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic [DEPTH-1:0]  idx_hit;
  logic [DATA_W-1:0] idx_data [DEPTH];
  logic [CNT_W-1:0]  cnt_next;

  // Index 0 is hardwired: it never takes a write and never clears/sets busy.
  assign idx_hit[0]  = 1'b0;
  assign idx_data[0] = '0;

  for (genvar j = 1; j < DEPTH; j++) begin : g_idx
    grf_wr_select #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NUM_WR(NUM_WR)
    ) u_sel (
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .addr   (ADDR_W'(j)),
      .hit    (idx_hit[j]),
      .data   (idx_data[j])
    );
  end

  // Register array: clear on reset, otherwise take the resolved write data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int j = 0; j < DEPTH; j++) regs[j] <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if (idx_hit[j]) regs[j] <= idx_data[j];
      end
    end
  end

  // Next busy vector: writeback clears, issue sets afterwards so a new
  // producer supersedes a same-cycle writeback to the same index.
  always_comb begin
    busy_next = busy & ~idx_hit;
    if (issue_en && (issue_addr != ADDR_W'(REG_ZERO))) busy_next[issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Population count of the next busy vector, registered alongside it.
  always_comb begin
    cnt_next = '0;
    for (int j = 0; j < DEPTH; j++) cnt_next = cnt_next + CNT_W'(busy_next[j]);
  end

  // Scoreboard state and its registered count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              byp_hit;
    logic              use_byp;
    logic [DATA_W-1:0] byp_data;

    assign addr    = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
    assign is_zero = (addr == ADDR_W'(REG_ZERO));
    assign use_byp = (BYPASS != 0) && byp_hit;

    grf_wr_select #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NUM_WR(NUM_WR)
    ) u_byp (
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .addr   (addr),
      .hit    (byp_hit),
      .data   (byp_data)
    );

    assign rd_data[slice_lo(i, DATA_W) +: DATA_W] =
      is_zero ? '0 : (use_byp ? byp_data : regs[addr]);
    assign rd_busy[i] = ~is_zero & busy[addr] & ~use_byp;
  end

  assign stall = |(rd_used & rd_busy);

endmodule
